// File: rtl/prog_mem_pkg.sv
// Shared definitions for the CPU program/data memory and its readback path.
package prog_mem_pkg;

  // Memory geometry, common to the memory, the programming port and the reader.
  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  // Reader sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } rd_state_t;

  // One buffered readback word together with the address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0] adrs;
    logic [DATA_W-1:0] data;
  } rd_entry_t;

endpackage

// File: rtl/rd_stream_fifo.sv
// Small synchronous FIFO of {adrs, data} entries feeding the readback stream.
// A push is accepted while full if a pop happens in the same cycle; flush
// empties the FIFO on the next edge and wins over push/pop.
module rd_stream_fifo
  import prog_mem_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  rd_entry_t        wr_entry,
  output rd_entry_t        rd_entry,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  rd_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointer advance with wrap, valid for non power-of-two depths too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(DEPTH));
  assign count     = r_count;
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign rd_entry  = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state is updated with <= so every register samples pre-edge values.
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Entry storage.
  // NOTE: storage has no reset; occupancy decides validity, so the array can map to plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/prog_mem_reader.sv
// Readback engine: while the CPU is halted, reads a block of words from the
// memory read port and streams them out on a valid/ready interface.
// Word widths come from prog_mem_pkg. FIFO_DEPTH must be >= RD_LAT+1 for
// full throughput and correct credit accounting.
module prog_mem_reader
  import prog_mem_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_en,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_adrs,
  input  logic [ADDR_W:0]   count,
  output logic              r_enable,
  output logic [ADDR_W-1:0] r_adrs,
  input  logic [DATA_W-1:0] r_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic [ADDR_W-1:0] dout_adrs,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W = $clog2(FIFO_DEPTH + RD_LAT + 2);
  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W + 1)'(1);

  rd_state_t         r_state;
  logic [ADDR_W-1:0] r_cur_adrs;
  logic [ADDR_W:0]   r_remaining;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;
  logic [RD_LAT-1:0] r_pipe_vld;
  logic [ADDR_W-1:0] r_pipe_adrs [RD_LAT];

  logic              w_active;
  logic              w_abort;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic              w_drained;
  logic [CRD_W-1:0]  w_infl;
  logic [CRD_W-1:0]  w_used;
  logic [CRD_W-1:0]  w_cap;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [OCC_W-1:0]  w_fifo_count;
  rd_entry_t         w_ret_entry;
  rd_entry_t         w_head;

  assign w_active = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
  assign w_abort  = w_active && cpu_en;
  assign w_pop    = !w_fifo_empty && dout_ready;

  // Reads currently travelling through the memory latency pipe.
  always_comb begin
    // NOTE: default assignment first so no latch is inferred.
    w_infl = '0;
    for (int i = 0; i < RD_LAT; i++) w_infl = w_infl + CRD_W'(r_pipe_vld[i]);
  end

  // Credit > 0 when buffered + in-flight words leave room, counting the slot
  // freed by a pop this cycle so a steady stream sustains one word per cycle.
  assign w_used  = CRD_W'(w_fifo_count) + w_infl;
  assign w_cap   = CRD_W'(FIFO_DEPTH) + CRD_W'(w_pop);
  assign w_issue = (r_state == ST_ISSUE) && !cpu_en && (w_used < w_cap);

  // Last word leaves the FIFO this cycle (or already has) with nothing pending.
  assign w_drained = (w_infl == '0) &&
                     ((w_fifo_count == '0) || ((w_fifo_count == OCC_W'(1)) && w_pop));

  // Returning data lines up with its address at the end of the delay pipe.
  assign w_ret_entry = '{adrs: r_pipe_adrs[RD_LAT-1], data: r_data};
  assign w_push      = r_pipe_vld[RD_LAT-1] && !w_abort && (!w_fifo_full || w_pop);

  // Memory latency pipe: carries issue strobes and addresses RD_LAT cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) r_pipe_adrs[i] <= '0;
    end else if (w_abort) begin
      r_pipe_vld <= '0;
    end else begin
      r_pipe_vld[0]  <= w_issue;
      r_pipe_adrs[0] <= r_cur_adrs;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_adrs[i] <= r_pipe_adrs[i-1];
      end
    end
  end

  // Dump sequencer with registered busy/done/aborted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_cur_adrs  <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !cpu_en) begin
            r_cur_adrs  <= base_adrs;
            r_remaining <= count;
            r_busy      <= 1'b1;
            // An empty dump skips issuing and finishes through the drain check.
            r_state     <= (count == '0) ? ST_DRAIN : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cpu_en) begin
            r_state   <= ST_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
          end else if (w_issue) begin
            r_cur_adrs  <= r_cur_adrs + 1'b1;
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == REM_ONE) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (cpu_en) begin
            r_state   <= ST_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
          end else if (w_drained) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  rd_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (OCC_W)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (w_push),
    .pop      (w_pop),
    .flush    (w_abort),
    .wr_entry (w_ret_entry),
    .rd_entry (w_head),
    .full     (w_fifo_full),
    .empty    (w_fifo_empty),
    .count    (w_fifo_count)
  );

  assign r_enable   = w_issue;
  assign r_adrs     = r_cur_adrs;
  assign dout_valid = !w_fifo_empty;
  // Head entry is forced to zero while empty so the stream reads 0 out of reset.
  assign dout_data  = w_fifo_empty ? '0 : w_head.data;
  assign dout_adrs  = w_fifo_empty ? '0 : w_head.adrs;
  assign busy       = r_busy;
  assign done       = r_done;
  assign aborted    = r_aborted;

endmodule

// File: tb/tb_prog_mem_reader.sv
// Scoreboard bench for prog_mem_reader: the driver pushes expected
// {adrs,data} words; a negedge monitor pops and compares each transfer.
module tb_prog_mem_reader;
  import prog_mem_pkg::*;

  localparam int RD_LAT     = 1;
  localparam int FIFO_DEPTH = 2;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              cpu_en = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_adrs = '0;
  logic [ADDR_W:0]   count = '0;
  logic              r_enable;
  logic [ADDR_W-1:0] r_adrs;
  logic [DATA_W-1:0] r_data = '0;
  logic              dout_valid;
  logic              dout_ready = 1'b0;
  logic [DATA_W-1:0] dout_data;
  logic [ADDR_W-1:0] dout_adrs;
  logic              busy;
  logic              done;
  logic              aborted;

  prog_mem_reader #(
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cpu_en     (cpu_en),
    .start      (start),
    .base_adrs  (base_adrs),
    .count      (count),
    .r_enable   (r_enable),
    .r_adrs     (r_adrs),
    .r_data     (r_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .dout_adrs  (dout_adrs),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle synchronous read port.
  logic [DATA_W-1:0] mem [1 << ADDR_W];
  always @(posedge clk) if (r_enable) r_data <= mem[r_adrs];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef logic [ADDR_W+DATA_W-1:0] exp_t;
  exp_t exp_q[$];

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back({a, d});
  endtask

  // Monitor state
  logic              done_seen = 1'b0;
  logic              done_abt = 1'b0;
  int                done_cyc = 0;
  int                ren_cnt = 0;
  int                vld_cnt = 0;
  int                first_ren = -1;
  int                first_vld = -1;
  int                last_xfer = -1;
  int                outstanding = 0;
  int                start_cyc = 0;
  logic              prev_stall = 1'b0;
  logic              prev_cpu_en = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic [ADDR_W-1:0] prev_adrs = '0;

  always @(negedge clk) begin
    if (!resetn) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (r_enable) begin
        ren_cnt++;
        if (first_ren < 0) first_ren = cyc;
      end
      if (dout_valid) begin
        vld_cnt++;
        if (first_vld < 0) first_vld = cyc;
      end
      if (prev_stall && !prev_cpu_en) begin
        check("hold_valid", 64'(dout_valid), 64'(1));
        check("hold_word", 64'({dout_adrs, dout_data}), 64'({prev_adrs, prev_data}));
      end
      if (dout_valid && dout_ready) begin
        check("sb_word_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) check("sb_word", 64'({dout_adrs, dout_data}), 64'(exp_q.pop_front()));
        last_xfer = cyc;
      end
      if (done) begin
        outstanding = 0;
        done_seen   = 1'b1;
        done_cyc    = cyc;
        done_abt    = aborted;
        check("busy_low_at_done", 64'(busy), 64'(0));
      end else begin
        outstanding += int'(r_enable) - int'(dout_valid && dout_ready);
        if (r_enable) check("credit_bound", 64'(outstanding <= FIFO_DEPTH), 64'(1));
      end
      prev_stall  = dout_valid && !dout_ready;
      prev_cpu_en = cpu_en;
      prev_data   = dout_data;
      prev_adrs   = dout_adrs;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n);
    @(posedge clk);
    #1;
    base_adrs = b;
    count     = n;
    start     = 1'b1;
    start_cyc = cyc;
    done_seen = 1'b0;
    ren_cnt   = 0;
    vld_cnt   = 0;
    first_ren = -1;
    first_vld = -1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic exp_abt);
    for (int i = 0; i < 400 && !done_seen; i++) @(posedge clk);
    #1;
    check({name, "_done_seen"}, 64'(done_seen), 64'(1));
    if (done_seen) check({name, "_aborted"}, 64'(done_abt), 64'(exp_abt));
  endtask

  task automatic check_reset_outs(input string name);
    check(name, 64'({r_enable, r_adrs, dout_valid, dout_data, dout_adrs, busy, done, aborted}), 64'(0));
  endtask

  logic [7:0] pat = 8'b0110_1001;  // ready sequence 1,0,0,1,0,1,1,0 from bit 0

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hA500_0000 | i;
    mem[11'h000] = 32'h0000_000d;
    mem[11'h001] = 32'h0000_000b;
    mem[11'h002] = 32'h0000_008f;
    mem[11'h003] = 32'h0000_0000;
    mem[11'h7ff] = 32'hffff_ffff;

    // Reset state
    tick();
    tick();
    check_reset_outs("reset_outputs");
    resetn = 1'b1;
    tick();

    // Basic 4-word dump, consumer always ready
    dout_ready = 1'b1;
    push_exp(11'h000, 32'h0000_000d);
    push_exp(11'h001, 32'h0000_000b);
    push_exp(11'h002, 32'h0000_008f);
    push_exp(11'h003, 32'h0000_0000);
    drive_start(11'h000, 12'd4);
    check("t1_busy_after_start", 64'(busy), 64'(1));
    wait_done("t1", 1'b0);
    check("t1_first_latency", 64'(first_vld - first_ren), 64'(RD_LAT + 1));
    check("t1_back_to_back", 64'(last_xfer - first_vld), 64'(3));
    check("t1_done_after_last", 64'(done_cyc - last_xfer), 64'(1));
    check("t1_queue_empty", 64'(exp_q.size()), 64'(0));

    // Same dump under a stalling consumer
    dout_ready = 1'b1;
    push_exp(11'h000, 32'h0000_000d);
    push_exp(11'h001, 32'h0000_000b);
    push_exp(11'h002, 32'h0000_008f);
    push_exp(11'h003, 32'h0000_0000);
    drive_start(11'h000, 12'd4);
    for (int i = 0; i < 300 && !done_seen; i++) begin
      dout_ready = pat[i % 8];
      tick();
    end
    check("t2_done_seen", 64'(done_seen), 64'(1));
    check("t2_aborted", 64'(done_abt), 64'(0));
    check("t2_queue_empty", 64'(exp_q.size()), 64'(0));

    // Address wrap
    dout_ready = 1'b1;
    push_exp(11'h7ff, 32'hffff_ffff);
    push_exp(11'h000, 32'h0000_000d);
    drive_start(11'h7ff, 12'd2);
    wait_done("t3", 1'b0);
    check("t3_queue_empty", 64'(exp_q.size()), 64'(0));

    // Empty dump
    drive_start(11'h005, 12'd0);
    wait_done("t4", 1'b0);
    check("t4_done_latency", 64'(done_cyc - start_cyc), 64'(2));
    check("t4_no_reads", 64'(ren_cnt), 64'(0));
    check("t4_no_words", 64'(vld_cnt), 64'(0));

    // Abort with consumer stalled
    dout_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_exp(11'(i), mem[i]);
    drive_start(11'h000, 12'd16);
    for (int i = 0; i < 5; i++) tick();
    check("t5_buffered", 64'(dout_valid), 64'(1));
    cpu_en = 1'b1;
    #1;
    check("t5_ren_gated", 64'(r_enable), 64'(0));
    tick();
    check("t5_flushed", 64'(dout_valid), 64'(0));
    wait_done("t5", 1'b1);
    exp_q.delete();
    drive_start(11'h000, 12'd4);
    for (int i = 0; i < 4; i++) tick();
    check("t5_start_ignored_busy", 64'(busy), 64'(0));
    check("t5_start_ignored_reads", 64'(ren_cnt), 64'(0));
    check("t5_start_ignored_done", 64'(done_seen), 64'(0));
    cpu_en = 1'b0;
    tick();

    // Abort during steady streaming: r_enable drops combinationally
    dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_exp(11'(i), mem[i]);
    drive_start(11'h000, 12'd16);
    for (int i = 0; i < 3; i++) tick();
    check("t6_streaming", 64'(r_enable), 64'(1));
    cpu_en = 1'b1;
    #1;
    check("t6_ren_drop", 64'(r_enable), 64'(0));
    tick();
    check("t6_flushed", 64'(dout_valid), 64'(0));
    wait_done("t6", 1'b1);
    exp_q.delete();
    cpu_en = 1'b0;
    tick();

    // Reset mid-dump, then a fresh dump
    for (int i = 0; i < 16; i++) push_exp(11'(i), mem[i]);
    drive_start(11'h000, 12'd16);
    for (int i = 0; i < 3; i++) tick();
    check("t7_mid_dump_busy", 64'(busy), 64'(1));
    resetn = 1'b0;
    #1;
    check_reset_outs("t7_reset_outputs");
    exp_q.delete();
    tick();
    tick();
    resetn = 1'b1;
    tick();
    push_exp(11'h000, 32'h0000_000d);
    push_exp(11'h001, 32'h0000_000b);
    push_exp(11'h002, 32'h0000_008f);
    push_exp(11'h003, 32'h0000_0000);
    drive_start(11'h000, 12'd4);
    wait_done("t7", 1'b0);
    check("t7_queue_empty", 64'(exp_q.size()), 64'(0));

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case the run never reaches its summary
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
